// File: rtl/puf_resp_ctrl_if.sv
// Handshake and counter bus between the PUF response controller and its
// environment: run request/status plus the ring-oscillator counter pair.
interface puf_resp_ctrl_if #(
  parameter int N     = 16,
  parameter int NBITS = 8
) ();
  localparam int SW = $clog2(NBITS);

  logic             start;
  logic [N-1:0]     cnt_a;
  logic [N-1:0]     cnt_b;
  logic             rco_a;
  logic             rco_b;
  logic             cnt_clr;
  logic             cnt_up;
  logic [SW-1:0]    sel;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] resp;
  logic             err;

  modport master (
    output start, cnt_a, cnt_b, rco_a, rco_b,
    input  cnt_clr, cnt_up, sel, busy, done, resp, err
  );

  modport slave (
    input  start, cnt_a, cnt_b, rco_a, rco_b,
    output cnt_clr, cnt_up, sel, busy, done, resp, err
  );
endinterface

// File: rtl/puf_resp_ctrl.sv
// PUF response controller: for each response bit, clears an RO counter pair,
// counts for WIN cycles, waits out the counter output latency, then records
// whether counter A beat counter B. Overflow during a run sets a sticky err.
//
// state   | meaning
// IDLE    | waiting for start; resp/err hold last run
// CLEAR   | counters cleared for one cycle, window timer loaded
// COUNT   | counters enabled for WIN cycles
// SETTLE  | two cycles for counter outputs to become valid
// COMPARE | resp[sel] <= cnt_a > cnt_b, advance sel or finish
// DONE    | one-cycle done pulse
module puf_resp_ctrl #(
  parameter int N     = 16,
  parameter int WIN   = 1024,
  parameter int NBITS = 8
) (
  input logic             clk,
  input logic             clr,
  puf_resp_ctrl_if.slave  bus
);
  localparam int SW = $clog2(NBITS);
  localparam int TW = $clog2(WIN);

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, SETTLE, COMPARE, DONE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [NBITS-1:0] resp_q, resp_d;
  logic             err_q, err_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             cnt_up_q, cnt_up_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     cnt_a_w, cnt_b_w;

  assign cnt_a_w = bus.cnt_a;
  assign cnt_b_w = bus.cnt_b;

  // Next-state, datapath and next-output computation; outputs are decoded
  // from the next state so they can be registered without a cycle of lag.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    resp_d  = resp_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          sel_d   = '0;
          resp_d  = '0;
          err_d   = 1'b0;
        end
      end
      CLEAR: begin
        state_d = COUNT;
        timer_d = '0;
      end
      COUNT: begin
        if (timer_q == TW'(WIN - 1)) begin
          state_d = SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SETTLE: begin
        // timer reused to count the two latency cycles
        if (timer_q == TW'(1)) state_d = COMPARE;
        else                   timer_d = timer_q + 1'b1;
      end
      COMPARE: begin
        resp_d[sel_q] = (cnt_a_w > cnt_b_w);
        if (sel_q == SW'(NBITS - 1)) begin
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // overflow is only meaningful while the counters run or settle
    if ((state_q == COUNT || state_q == SETTLE) && (bus.rco_a || bus.rco_b))
      err_d = 1'b1;

    cnt_clr_d = (state_d == CLEAR);
    cnt_up_d  = (state_d == COUNT);
    busy_d    = (state_d == CLEAR) || (state_d == COUNT) ||
                (state_d == SETTLE) || (state_d == COMPARE);
    done_d    = (state_d == DONE);
  end

  // All state and output registers; clr forces the idle, all-zero condition.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sel_q     <= '0;
      resp_q    <= '0;
      err_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
      cnt_up_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      cnt_clr_q <= cnt_clr_d;
      cnt_up_q  <= cnt_up_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.cnt_clr = cnt_clr_q;
  assign bus.cnt_up  = cnt_up_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.resp    = resp_q;
  assign bus.err     = err_q;
endmodule
